// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised VGA raster timing generator with clock-enable
//               divider, pause control, registered syncs and raster strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 56,
    parameter int H_SYNC   = 120,
    parameter int H_BP     = 64,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 37,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 23,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CLK_DIV  = 1,
    parameter int COL_W    = 12,
    parameter int ROW_W    = 11
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    output logic [COL_W-1:0] display_col,
    output logic [ROW_W-1:0] display_row,
    output logic             visible,
    output logic             hsync,
    output logic             vsync,
    output logic             pix_tick,
    output logic             line_start,
    output logic             frame_start,
    output logic             vblank_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [COL_W-1:0] C_COL_LAST = COL_W'(H_TOTAL - 1);
    localparam logic [COL_W-1:0] C_H_ACTIVE = COL_W'(H_ACTIVE);
    localparam logic [COL_W-1:0] C_HS_START = COL_W'(H_ACTIVE + H_FP);
    localparam logic [COL_W-1:0] C_HS_END   = COL_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [ROW_W-1:0] C_ROW_LAST = ROW_W'(V_TOTAL - 1);
    localparam logic [ROW_W-1:0] C_V_ACTIVE = ROW_W'(V_ACTIVE);
    localparam logic [ROW_W-1:0] C_VS_START = ROW_W'(V_ACTIVE + V_FP);
    localparam logic [ROW_W-1:0] C_VS_END   = ROW_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] r_div_cnt;
    logic             w_advance;
    logic             w_col_wrap;
    logic [COL_W-1:0] w_next_col;
    logic [ROW_W-1:0] w_next_row;
    logic             w_next_visible;
    logic             w_next_hs_act;
    logic             w_next_vs_act;

    assign w_advance  = enable && (r_div_cnt == C_DIV_LAST);
    assign w_col_wrap = (display_col == C_COL_LAST);
    assign w_next_col = w_col_wrap ? '0 : display_col + 1'b1;
    assign w_next_row = !w_col_wrap ? display_row :
                        (display_row == C_ROW_LAST) ? '0 : display_row + 1'b1;

    // Outputs are decoded from the next raster position so every output
    // register updates on the same edge as the counters.
    assign w_next_visible = (w_next_col < C_H_ACTIVE) && (w_next_row < C_V_ACTIVE);
    assign w_next_hs_act  = (w_next_col >= C_HS_START) && (w_next_col < C_HS_END);
    assign w_next_vs_act  = (w_next_row >= C_VS_START) && (w_next_row < C_VS_END);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_div_cnt    <= '0;
            display_col  <= C_COL_LAST;
            display_row  <= C_ROW_LAST;
            visible      <= 1'b0;
            hsync        <= ~HS_POL;
            vsync        <= ~VS_POL;
            pix_tick     <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
        end else begin
            pix_tick     <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
            // Pausing freezes the divider phase so resumption keeps pixel cadence.
            if (enable) begin
                r_div_cnt <= w_advance ? '0 : r_div_cnt + 1'b1;
            end
            if (w_advance) begin
                display_col  <= w_next_col;
                display_row  <= w_next_row;
                visible      <= w_next_visible;
                hsync        <= w_next_hs_act ? HS_POL : ~HS_POL;
                vsync        <= w_next_vs_act ? VS_POL : ~VS_POL;
                pix_tick     <= 1'b1;
                line_start   <= (w_next_col == '0);
                frame_start  <= (w_next_col == '0) && (w_next_row == '0);
                vblank_start <= (w_next_col == '0) && (w_next_row == C_V_ACTIVE);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Scoreboard bench for vga_timing_gen; three instances cover
//               default timing, small active-high timing and a 3x divider.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    logic en_a = 1'b1, en_b = 1'b1, en_c = 1'b1;
    logic done = 1'b0;

    logic [11:0] a_col;  logic [10:0] a_row;
    logic a_vis, a_hs, a_vs, a_pt, a_ls, a_fs, a_vb;
    logic [3:0]  b_col;  logic [2:0]  b_row;
    logic b_vis, b_hs, b_vs, b_pt, b_ls, b_fs, b_vb;
    logic [3:0]  c_col;  logic [2:0]  c_row;
    logic c_vis, c_hs, c_vs, c_pt, c_ls, c_fs, c_vb;

    vga_timing_gen u_a (
        .clock(clk), .reset(rst_a), .enable(en_a),
        .display_col(a_col), .display_row(a_row), .visible(a_vis),
        .hsync(a_hs), .vsync(a_vs), .pix_tick(a_pt), .line_start(a_ls),
        .frame_start(a_fs), .vblank_start(a_vb)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1), .COL_W(4), .ROW_W(3)
    ) u_b (
        .clock(clk), .reset(rst_b), .enable(en_b),
        .display_col(b_col), .display_row(b_row), .visible(b_vis),
        .hsync(b_hs), .vsync(b_vs), .pix_tick(b_pt), .line_start(b_ls),
        .frame_start(b_fs), .vblank_start(b_vb)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(3), .COL_W(4), .ROW_W(3)
    ) u_c (
        .clock(clk), .reset(rst_c), .enable(en_c),
        .display_col(c_col), .display_row(c_row), .visible(c_vis),
        .hsync(c_hs), .vsync(c_vs), .pix_tick(c_pt), .line_start(c_ls),
        .frame_start(c_fs), .vblank_start(c_vb)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Flag vector order: {visible, hsync, vsync, pix_tick, line_start, frame_start, vblank_start}
    typedef struct {
        int unsigned cyc;
        int          id;
        string       name;
        int          col;
        int          row;
        logic [6:0]  flags;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic push(input int unsigned t, input int id, input string nm,
                        input int col, input int row, input logic [6:0] f);
        exp_t e;
        e.cyc = t; e.id = id; e.name = nm; e.col = col; e.row = row; e.flags = f;
        sb.push_back(e);
    endtask

    function automatic void get_act(input int id, output int col, output int row,
                                    output logic [6:0] f);
        case (id)
            0: begin col = int'(a_col); row = int'(a_row);
                     f = {a_vis, a_hs, a_vs, a_pt, a_ls, a_fs, a_vb}; end
            1: begin col = int'(b_col); row = int'(b_row);
                     f = {b_vis, b_hs, b_vs, b_pt, b_ls, b_fs, b_vb}; end
            default: begin col = int'(c_col); row = int'(c_row);
                     f = {c_vis, c_hs, c_vs, c_pt, c_ls, c_fs, c_vb}; end
        endcase
    endfunction

    // Monitor: compares every expectation stamped for the current cycle.
    always @(negedge clk) begin
        int         acol, arow;
        logic [6:0] af;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                get_act(sb[i].id, acol, arow, af);
                tests++;
                if (acol != sb[i].col || arow != sb[i].row || af !== sb[i].flags) begin
                    fails++;
                    $display("FAIL %s @cyc %0d: got col=%0d row=%0d flags=%b, expected col=%0d row=%0d flags=%b",
                             sb[i].name, cyc, acol, arow, af, sb[i].col, sb[i].row, sb[i].flags);
                end
                sb.delete(i);
            end
        end
        if (done) begin
            foreach (sb[i]) begin
                tests++;
                fails++;
                $display("FAIL %s: expectation for cycle %0d never checked (now %0d)",
                         sb[i].name, sb[i].cyc, cyc);
            end
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    task automatic wait_cyc(input int unsigned t);
        while (cyc < t) @(negedge clk);
    endtask

    int unsigned r;

    initial begin
        repeat (2) @(negedge clk);
        push(cyc + 1, 0, "a_reset", 1039, 665, 7'b0110000);
        push(cyc + 1, 1, "b_reset",   13,   6, 7'b0000000);
        push(cyc + 1, 2, "c_reset",   13,   6, 7'b0110000);
        @(negedge clk);
        @(negedge clk);
        r = cyc;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        // Default 1040x666 timing, one pixel per clock
        push(r + 1,     0, "a_first",       0,  0, 7'b1111110);
        push(r + 2,     0, "a_col1",        1,  0, 7'b1111000);
        push(r + 800,   0, "a_col799",    799,  0, 7'b1111000);
        push(r + 801,   0, "a_col800",    800,  0, 7'b0111000);
        push(r + 856,   0, "a_col855",    855,  0, 7'b0111000);
        push(r + 857,   0, "a_hs_start",  856,  0, 7'b0011000);
        push(r + 976,   0, "a_hs_last",   975,  0, 7'b0011000);
        push(r + 977,   0, "a_hs_end",    976,  0, 7'b0111000);
        push(r + 1040,  0, "a_col1039",  1039,  0, 7'b0111000);
        push(r + 1041,  0, "a_line1",       0,  1, 7'b1111100);
        push(r + 10901, 0, "a_500_10",    500, 10, 7'b1111000);
        push(r + 10902, 0, "a_pause1",    500, 10, 7'b1110000);
        push(r + 10908, 0, "a_pause7",    500, 10, 7'b1110000);
        push(r + 10909, 0, "a_resume",    501, 10, 7'b1111000);
        push(r + 10910, 0, "a_resume2",   502, 10, 7'b1111000);

        // 14x7 timing, active-high syncs
        push(r + 1,   1, "b_first",     0, 0, 7'b1001110);
        push(r + 11,  1, "b_hs_start", 10, 0, 7'b0101000);
        push(r + 12,  1, "b_hs_last",  11, 0, 7'b0101000);
        push(r + 13,  1, "b_hs_end",   12, 0, 7'b0001000);
        push(r + 15,  1, "b_line1",     0, 1, 7'b1001100);
        push(r + 57,  1, "b_vblank",    0, 4, 7'b0001101);
        push(r + 71,  1, "b_vs_start",  0, 5, 7'b0011100);
        push(r + 84,  1, "b_vs_last",  13, 5, 7'b0011000);
        push(r + 85,  1, "b_vs_end",    0, 6, 7'b0001100);
        push(r + 98,  1, "b_frame_end",13, 6, 7'b0001000);
        push(r + 99,  1, "b_wrap",      0, 0, 7'b1001110);
        push(r + 129, 1, "b_pre_rst",   2, 2, 7'b1001000);
        push(r + 130, 1, "b_async_rst",13, 6, 7'b0000000);
        push(r + 133, 1, "b_rst_held", 13, 6, 7'b0000000);
        push(r + 134, 1, "b_rst_first", 0, 0, 7'b1001110);

        // 14x7 timing, active-low syncs, three clocks per pixel
        push(r + 2,   2, "c_not_yet",  13, 6, 7'b0110000);
        push(r + 3,   2, "c_first",     0, 0, 7'b1111110);
        push(r + 4,   2, "c_strobe_1w", 0, 0, 7'b1110000);
        push(r + 6,   2, "c_col1",      1, 0, 7'b1111000);
        push(r + 33,  2, "c_hs_start", 10, 0, 7'b0011000);
        push(r + 35,  2, "c_hs_hold",  10, 0, 7'b0010000);
        push(r + 39,  2, "c_hs_end",   12, 0, 7'b0111000);
        push(r + 171, 2, "c_vblank",    0, 4, 7'b0111101);
        push(r + 172, 2, "c_vblank_1w", 0, 4, 7'b0110000);
        push(r + 213, 2, "c_vs_start",  0, 5, 7'b0101100);
        push(r + 296, 2, "c_frame_end",13, 6, 7'b0110000);
        push(r + 297, 2, "c_wrap",      0, 0, 7'b1111110);
        push(r + 303, 2, "c_paused",    0, 0, 7'b1110000);
        push(r + 304, 2, "c_resumed",   0, 0, 7'b1110000);
        push(r + 305, 2, "c_div_kept",  1, 0, 7'b1111000);

        // Reset b between clock edges, mid-frame
        wait_cyc(r + 129);
        @(posedge clk);
        #2 rst_b = 1'b1;
        wait_cyc(r + 133);
        rst_b = 1'b0;

        // Pause c one clock into a divider period
        wait_cyc(r + 298);
        en_c = 1'b0;
        wait_cyc(r + 303);
        en_c = 1'b1;

        // Pause a at (500,10) for seven clocks
        wait_cyc(r + 10901);
        en_a = 1'b0;
        wait_cyc(r + 10908);
        en_a = 1'b1;

        wait_cyc(r + 10915);
        done = 1'b1;
    end

endmodule
`default_nettype wire
